// File: rtl/apb_master_ctrl_if.sv
// ---------------------------------------------------------------------------
// apb_master_ctrl_if
//   Bundles the command/response handshake and the APB bus of
//   apb_master_ctrl into one interface.
//
//   Command/response handshake:
//     A command is accepted on a rising edge where cmd_valid && cmd_ready.
//     cmd_ready is high only while the controller is idle. The requester must
//     hold cmd_write/cmd_addr/cmd_wdata stable while cmd_valid is high and
//     not yet accepted. Completion is a single-cycle rsp_valid pulse. There
//     is no rsp_ready, so the response cannot be stalled. rsp_rdata, rsp_err
//     and rsp_timeout hold their values until the next response.
//
//   Signals:
//     cmd_valid, cmd_write, cmd_addr, cmd_wdata[7:0] : command in
//     cmd_ready                                      : command accept
//     rsp_valid, rsp_rdata[7:0], rsp_err, rsp_timeout: response out
//     err_count[7:0]                                 : saturating error count
//     PSELx, PENABLE, PADDR, PWRITE, PWDATA[7:0]     : APB requester outputs
//     PREADY, PSLVERR, PRDATA[7:0]                   : APB completer inputs
//     fsm_state[1:0]                                 : controller state, debug
//
//   Modports:
//     master : the controller side (apb_master_ctrl)
//     slave  : the environment side (command source, APB completer)
// ---------------------------------------------------------------------------
interface apb_master_ctrl_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_write;
   logic       cmd_addr;
   logic [7:0] cmd_wdata;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic       rsp_err;
   logic       rsp_timeout;
   logic [7:0] err_count;
   logic       PSELx;
   logic       PENABLE;
   logic       PADDR;
   logic       PWRITE;
   logic [7:0] PWDATA;
   logic       PREADY;
   logic       PSLVERR;
   logic [7:0] PRDATA;
   logic [1:0] fsm_state;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
      input  PREADY, PSLVERR, PRDATA,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, err_count,
      output PSELx, PENABLE, PADDR, PWRITE, PWDATA, fsm_state
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
      output PREADY, PSLVERR, PRDATA,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, err_count,
      input  PSELx, PENABLE, PADDR, PWRITE, PWDATA, fsm_state
   );
endinterface

// File: rtl/apb_master_ctrl.sv
// ---------------------------------------------------------------------------
// apb_master_ctrl
//   Single-outstanding APB requester. Takes one command at a time from a
//   valid/ready command port, runs it as an APB SETUP + ACCESS transfer and
//   returns a one-cycle response pulse with read data and error/timeout
//   status. An ACCESS phase that sees no PREADY for TIMEOUT cycles is
//   aborted and reported as a timeout error. Every response with an error
//   bumps a saturating 8-bit error counter.
//
//   Parameters:
//     TIMEOUT : ACCESS cycles without PREADY before abort (2..255)
//
//   Ports:
//     PCLK   : clock, everything on the rising edge
//     PRESET : synchronous active-high reset
//     bus    : apb_master_ctrl_if.master (command, response, APB, debug state)
//
//   Every output except cmd_ready comes straight from a flop; cmd_ready is a
//   decode of the IDLE state so a command can be taken in the same cycle a
//   response is presented (back-to-back, one transfer per 3 cycles).
// ---------------------------------------------------------------------------
module apb_master_ctrl #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic              PCLK,
   input  logic              PRESET,
   apb_master_ctrl_if.master bus
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } state_t;

   // Last wait-counter value before abort: the counter is 0 in the first
   // ACCESS cycle, so TIMEOUT-1 is the TIMEOUT-th ACCESS cycle.
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   state_t     state, state_nxt;

   logic       psel_q,    psel_d;
   logic       penable_q, penable_d;
   logic       paddr_q,   paddr_d;
   logic       pwrite_q,  pwrite_d;
   logic [7:0] pwdata_q,  pwdata_d;
   logic       rsp_valid_q,   rsp_valid_d;
   logic [7:0] rsp_rdata_q,   rsp_rdata_d;
   logic       rsp_err_q,     rsp_err_d;
   logic       rsp_timeout_q, rsp_timeout_d;
   logic [7:0] err_count_q,   err_count_d;
   logic [7:0] wait_q,        wait_d;

   logic       accept;
   logic       expired;

   assign accept  = bus.cmd_valid && (state == ST_IDLE);
   assign expired = (wait_q == WAIT_LAST);

   // ------------------------------------------------------------------
   // State and output registers
   // ------------------------------------------------------------------
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state         <= ST_IDLE;
         psel_q        <= 1'b0;
         penable_q     <= 1'b0;
         paddr_q       <= 1'b0;
         pwrite_q      <= 1'b0;
         pwdata_q      <= 8'h00;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= 8'h00;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
         err_count_q   <= 8'h00;
         wait_q        <= 8'h00;
      end else begin
         state         <= state_nxt;
         psel_q        <= psel_d;
         penable_q     <= penable_d;
         paddr_q       <= paddr_d;
         pwrite_q      <= pwrite_d;
         pwdata_q      <= pwdata_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_err_q     <= rsp_err_d;
         rsp_timeout_q <= rsp_timeout_d;
         err_count_q   <= err_count_d;
         wait_q        <= wait_d;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (accept) state_nxt = ST_SETUP;
         ST_SETUP:  state_nxt = ST_ACCESS;
         // PREADY wins over an expiring wait counter.
         ST_ACCESS: if (bus.PREADY || expired) state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Next values of the registered outputs
   // ------------------------------------------------------------------
   always_comb begin
      psel_d        = psel_q;
      penable_d     = penable_q;
      paddr_d       = paddr_q;
      pwrite_d      = pwrite_q;
      pwdata_d      = pwdata_q;
      rsp_valid_d   = 1'b0;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_err_d     = rsp_err_q;
      rsp_timeout_d = rsp_timeout_q;
      err_count_d   = err_count_q;
      wait_d        = wait_q;

      case (state)
         ST_IDLE: begin
            if (accept) begin
               paddr_d   = bus.cmd_addr;
               pwrite_d  = bus.cmd_write;
               pwdata_d  = bus.cmd_wdata;
               psel_d    = 1'b1;
               penable_d = 1'b0;
            end
         end

         ST_SETUP: begin
            penable_d = 1'b1;
            wait_d    = 8'h00;
         end

         ST_ACCESS: begin
            if (bus.PREADY) begin
               // Normal completion: PSLVERR/PRDATA are only looked at here.
               psel_d        = 1'b0;
               penable_d     = 1'b0;
               rsp_valid_d   = 1'b1;
               rsp_err_d     = bus.PSLVERR;
               rsp_timeout_d = 1'b0;
               rsp_rdata_d   = pwrite_q ? 8'h00 : bus.PRDATA;
               if (bus.PSLVERR && (err_count_q != 8'hFF)) begin
                  err_count_d = err_count_q + 8'd1;
               end
            end else if (expired) begin
               psel_d        = 1'b0;
               penable_d     = 1'b0;
               rsp_valid_d   = 1'b1;
               rsp_err_d     = 1'b1;
               rsp_timeout_d = 1'b1;
               rsp_rdata_d   = 8'h00;
               if (err_count_q != 8'hFF) begin
                  err_count_d = err_count_q + 8'd1;
               end
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end

         default: begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Output drive
   // ------------------------------------------------------------------
   assign bus.cmd_ready   = (state == ST_IDLE);
   assign bus.PSELx       = psel_q;
   assign bus.PENABLE     = penable_q;
   assign bus.PADDR       = paddr_q;
   assign bus.PWRITE      = pwrite_q;
   assign bus.PWDATA      = pwdata_q;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_rdata   = rsp_rdata_q;
   assign bus.rsp_err     = rsp_err_q;
   assign bus.rsp_timeout = rsp_timeout_q;
   assign bus.err_count   = err_count_q;
   assign bus.fsm_state   = state;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// ---------------------------------------------------------------------------
// tb_apb_master_ctrl
//   Directed bench for apb_master_ctrl (TIMEOUT=16). One task per scenario,
//   each doing its own comparisons against hand-computed values.
//   Inputs are driven just after the falling edge, outputs sampled on the
//   falling edge, so every sample reflects the preceding rising edge.
// ---------------------------------------------------------------------------
module tb_apb_master_ctrl;

   logic PCLK;
   logic PRESET;

   apb_master_ctrl_if bus ();

   apb_master_ctrl #(.TIMEOUT(16)) dut (
      .PCLK   (PCLK),
      .PRESET (PRESET),
      .bus    (bus)
   );

   // ---------------- clock / reset ----------------
   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   initial begin
      #2000000;
      $display("FAIL global_watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int n_checks = 0;
   int n_pass   = 0;

   // results captured by run_xfer
   int         r_lat;
   int         r_psel;
   logic       r_got;
   logic       r_bad;
   logic [7:0] r_rdata;
   logic       r_err;
   logic       r_tmo;
   logic [7:0] r_errcnt;

   // ---------------- driver tasks ----------------
   // Issues one command and plays the APB completer: PREADY stays low for
   // 'waits' ACCESS cycles then goes high with PSLVERR=slverr, PRDATA=rd.
   // While PREADY is low, PSLVERR/PRDATA carry decoy values. r_lat counts
   // cycles from the accept edge to the rsp_valid cycle; r_psel counts PSELx
   // cycles; r_bad flags a protocol or address/data stability problem.
   task automatic run_xfer(input logic w, input logic a, input logic [7:0] wd,
                           input int waits, input logic slverr,
                           input logic [7:0] rd);
      int acc;
      @(negedge PCLK);
      bus.cmd_valid = 1'b1;
      bus.cmd_write = w;
      bus.cmd_addr  = a;
      bus.cmd_wdata = wd;
      bus.PREADY    = 1'b0;
      bus.PSLVERR   = 1'b0;
      bus.PRDATA    = 8'h00;
      r_lat = 0; r_psel = 0; r_got = 1'b0; r_bad = 1'b0; acc = 0;
      for (int c = 0; c < 100 && !r_got; c++) begin
         @(negedge PCLK);
         bus.cmd_valid = 1'b0;
         bus.cmd_write = ~w;
         bus.cmd_addr  = ~a;
         bus.cmd_wdata = ~wd;
         r_lat++;
         if (bus.rsp_valid) begin
            r_got    = 1'b1;
            r_rdata  = bus.rsp_rdata;
            r_err    = bus.rsp_err;
            r_tmo    = bus.rsp_timeout;
            r_errcnt = bus.err_count;
            if (bus.PSELx || bus.PENABLE) r_bad = 1'b1;
         end else begin
            if (bus.PENABLE && !bus.PSELx) r_bad = 1'b1;
            if (bus.PSELx) begin
               r_psel++;
               if (r_psel == 1 && bus.PENABLE) r_bad = 1'b1;
               if (bus.PADDR !== a || bus.PWRITE !== w || bus.PWDATA !== wd) r_bad = 1'b1;
            end
            if (bus.PENABLE) begin
               if (acc == waits) begin
                  bus.PREADY  = 1'b1;
                  bus.PSLVERR = slverr;
                  bus.PRDATA  = rd;
               end else begin
                  bus.PREADY  = 1'b0;
                  bus.PSLVERR = ~slverr;
                  bus.PRDATA  = ~rd;
               end
               acc++;
            end
         end
      end
      bus.PREADY  = 1'b0;
      bus.PSLVERR = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      PRESET = 1'b1;
      bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = 1'b0;
      bus.cmd_wdata = 8'h00; bus.PREADY = 1'b0; bus.PSLVERR = 1'b0; bus.PRDATA = 8'h00;
      repeat (3) @(negedge PCLK);
      n_checks++; if (bus.PSELx !== 1'b0) $display("FAIL reset_psel: got %b want 0", bus.PSELx); else n_pass++;
      n_checks++; if (bus.PENABLE !== 1'b0) $display("FAIL reset_penable: got %b want 0", bus.PENABLE); else n_pass++;
      n_checks++; if ({bus.PADDR, bus.PWRITE, bus.PWDATA} !== 10'h000) $display("FAIL reset_apb_regs: got %h want 000", {bus.PADDR, bus.PWRITE, bus.PWDATA}); else n_pass++;
      n_checks++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata} !== 11'h000) $display("FAIL reset_rsp: got %h want 000", {bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata}); else n_pass++;
      n_checks++; if (bus.err_count !== 8'h00) $display("FAIL reset_err_count: got %h want 00", bus.err_count); else n_pass++;
      PRESET = 1'b0;
      @(negedge PCLK);
      n_checks++; if (bus.cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b want 1", bus.cmd_ready); else n_pass++;
      n_checks++; if (bus.fsm_state !== 2'd0) $display("FAIL reset_state: got %0d want 0", bus.fsm_state); else n_pass++;
   endtask

   task automatic test_write();
      run_xfer(1'b1, 1'b0, 8'hA5, 0, 1'b0, 8'hEE);
      n_checks++; if (r_got !== 1'b1) $display("FAIL write_rsp_seen: got %b want 1", r_got); else n_pass++;
      n_checks++; if (r_lat !== 3) $display("FAIL write_latency: got %0d want 3", r_lat); else n_pass++;
      n_checks++; if (r_psel !== 2) $display("FAIL write_psel_cycles: got %0d want 2", r_psel); else n_pass++;
      n_checks++; if (r_bad !== 1'b0) $display("FAIL write_protocol: got %b want 0", r_bad); else n_pass++;
      n_checks++; if (r_err !== 1'b0 || r_tmo !== 1'b0) $display("FAIL write_status: got err=%b tmo=%b want 0/0", r_err, r_tmo); else n_pass++;
      n_checks++; if (r_rdata !== 8'h00) $display("FAIL write_rdata: got %h want 00", r_rdata); else n_pass++;
      n_checks++; if (r_errcnt !== 8'h00) $display("FAIL write_err_count: got %h want 00", r_errcnt); else n_pass++;
      @(negedge PCLK);
      n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL write_rsp_pulse: got %b want 0", bus.rsp_valid); else n_pass++;
      n_checks++; if (bus.PWDATA !== 8'hA5 || bus.PADDR !== 1'b0 || bus.PWRITE !== 1'b1) $display("FAIL write_idle_hold: got %h/%b/%b want a5/0/1", bus.PWDATA, bus.PADDR, bus.PWRITE); else n_pass++;
      n_checks++; if (bus.PSELx !== 1'b0) $display("FAIL write_idle_psel: got %b want 0", bus.PSELx); else n_pass++;
   endtask

   task automatic test_read_wait();
      run_xfer(1'b0, 1'b1, 8'h00, 3, 1'b0, 8'h3C);
      n_checks++; if (r_psel !== 5) $display("FAIL read_psel_cycles: got %0d want 5", r_psel); else n_pass++;
      n_checks++; if (r_lat !== 6) $display("FAIL read_latency: got %0d want 6", r_lat); else n_pass++;
      n_checks++; if (r_rdata !== 8'h3C) $display("FAIL read_rdata: got %h want 3c", r_rdata); else n_pass++;
      n_checks++; if (r_err !== 1'b0 || r_tmo !== 1'b0) $display("FAIL read_status: got err=%b tmo=%b want 0/0", r_err, r_tmo); else n_pass++;
      n_checks++; if (r_bad !== 1'b0) $display("FAIL read_protocol: got %b want 0", r_bad); else n_pass++;
      repeat (2) @(negedge PCLK);
      n_checks++; if (bus.rsp_rdata !== 8'h3C) $display("FAIL read_rdata_hold: got %h want 3c", bus.rsp_rdata); else n_pass++;
      n_checks++; if (bus.PADDR !== 1'b1 || bus.PWRITE !== 1'b0) $display("FAIL read_idle_hold: got %b/%b want 1/0", bus.PADDR, bus.PWRITE); else n_pass++;
   endtask

   task automatic test_error();
      run_xfer(1'b1, 1'b0, 8'h5A, 0, 1'b1, 8'hFF);
      n_checks++; if (r_err !== 1'b1) $display("FAIL error_rsp_err: got %b want 1", r_err); else n_pass++;
      n_checks++; if (r_tmo !== 1'b0) $display("FAIL error_rsp_timeout: got %b want 0", r_tmo); else n_pass++;
      n_checks++; if (r_errcnt !== 8'h01) $display("FAIL error_err_count: got %h want 01", r_errcnt); else n_pass++;
      n_checks++; if (r_rdata !== 8'h00) $display("FAIL error_rdata: got %h want 00", r_rdata); else n_pass++;
      n_checks++; if (r_lat !== 3) $display("FAIL error_latency: got %0d want 3", r_lat); else n_pass++;
   endtask

   task automatic test_timeout();
      // PREADY never rises: abort in the 16th ACCESS cycle.
      run_xfer(1'b0, 1'b1, 8'h00, 1000, 1'b0, 8'h77);
      n_checks++; if (r_got !== 1'b1) $display("FAIL timeout_rsp_seen: got %b want 1", r_got); else n_pass++;
      n_checks++; if (r_lat !== 18) $display("FAIL timeout_latency: got %0d want 18", r_lat); else n_pass++;
      n_checks++; if (r_psel !== 17) $display("FAIL timeout_psel_cycles: got %0d want 17", r_psel); else n_pass++;
      n_checks++; if (r_err !== 1'b1 || r_tmo !== 1'b1) $display("FAIL timeout_status: got err=%b tmo=%b want 1/1", r_err, r_tmo); else n_pass++;
      n_checks++; if (r_rdata !== 8'h00) $display("FAIL timeout_rdata: got %h want 00", r_rdata); else n_pass++;
      n_checks++; if (r_errcnt !== 8'h02) $display("FAIL timeout_err_count: got %h want 02", r_errcnt); else n_pass++;
      n_checks++; if (r_bad !== 1'b0) $display("FAIL timeout_protocol: got %b want 0", r_bad); else n_pass++;
      @(negedge PCLK);
      n_checks++; if (bus.rsp_timeout !== 1'b1) $display("FAIL timeout_hold: got %b want 1", bus.rsp_timeout); else n_pass++;
      // PREADY rises exactly in the 16th ACCESS cycle: normal completion.
      run_xfer(1'b0, 1'b1, 8'h00, 15, 1'b0, 8'h99);
      n_checks++; if (r_lat !== 18) $display("FAIL edge_latency: got %0d want 18", r_lat); else n_pass++;
      n_checks++; if (r_err !== 1'b0 || r_tmo !== 1'b0) $display("FAIL edge_status: got err=%b tmo=%b want 0/0", r_err, r_tmo); else n_pass++;
      n_checks++; if (r_rdata !== 8'h99) $display("FAIL edge_rdata: got %h want 99", r_rdata); else n_pass++;
      n_checks++; if (r_errcnt !== 8'h02) $display("FAIL edge_err_count: got %h want 02", r_errcnt); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int         n_rsp;
      int         last;
      logic       bad;
      logic [7:0] cnt_at_100;
      @(negedge PCLK);
      bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 1'b0; bus.cmd_wdata = 8'h11;
      bus.PREADY = 1'b1; bus.PSLVERR = 1'b1; bus.PRDATA = 8'h00;
      n_rsp = 0; last = 0; bad = 1'b0; cnt_at_100 = 8'h00;
      for (int cyc = 1; cyc <= 1000 && n_rsp < 260; cyc++) begin
         @(negedge PCLK);
         if (bus.PENABLE && !bus.PSELx) bad = 1'b1;
         if (bus.rsp_valid) begin
            n_rsp++;
            if (bus.PSELx) bad = 1'b1;
            if (cyc - last != 3) bad = 1'b1;
            last = cyc;
            if (n_rsp == 100) cnt_at_100 = bus.err_count;
            if (n_rsp == 260) bus.cmd_valid = 1'b0;
         end
      end
      bus.PREADY = 1'b0; bus.PSLVERR = 1'b0;
      n_checks++; if (n_rsp !== 260) $display("FAIL b2b_rsp_count: got %0d want 260", n_rsp); else n_pass++;
      n_checks++; if (last !== 780) $display("FAIL b2b_last_cycle: got %0d want 780", last); else n_pass++;
      n_checks++; if (bad !== 1'b0) $display("FAIL b2b_spacing_protocol: got %b want 0", bad); else n_pass++;
      n_checks++; if (cnt_at_100 !== 8'd102) $display("FAIL b2b_err_count_mid: got %0d want 102", cnt_at_100); else n_pass++;
      n_checks++; if (bus.err_count !== 8'hFF) $display("FAIL b2b_err_count_sat: got %h want ff", bus.err_count); else n_pass++;
      @(negedge PCLK);
      n_checks++; if (bus.cmd_ready !== 1'b1 || bus.PSELx !== 1'b0) $display("FAIL b2b_idle_after: got ready=%b psel=%b want 1/0", bus.cmd_ready, bus.PSELx); else n_pass++;
   endtask

   task automatic test_reset_access();
      logic seen_rsp;
      @(negedge PCLK);
      bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 1'b1; bus.cmd_wdata = 8'hC3;
      bus.PREADY = 1'b0;
      @(negedge PCLK);
      bus.cmd_valid = 1'b0;
      @(negedge PCLK);
      n_checks++; if (bus.PENABLE !== 1'b1 || bus.PSELx !== 1'b1) $display("FAIL rst_mid_in_access: got en=%b sel=%b want 1/1", bus.PENABLE, bus.PSELx); else n_pass++;
      @(negedge PCLK);
      PRESET = 1'b1;
      @(negedge PCLK);
      n_checks++; if (bus.PSELx !== 1'b0 || bus.PENABLE !== 1'b0) $display("FAIL rst_mid_apb_ctrl: got sel=%b en=%b want 0/0", bus.PSELx, bus.PENABLE); else n_pass++;
      n_checks++; if ({bus.PADDR, bus.PWRITE, bus.PWDATA} !== 10'h000) $display("FAIL rst_mid_apb_regs: got %h want 000", {bus.PADDR, bus.PWRITE, bus.PWDATA}); else n_pass++;
      n_checks++; if ({bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata} !== 11'h000) $display("FAIL rst_mid_rsp: got %h want 000", {bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata}); else n_pass++;
      n_checks++; if (bus.err_count !== 8'h00) $display("FAIL rst_mid_err_count: got %h want 00", bus.err_count); else n_pass++;
      PRESET = 1'b0;
      seen_rsp = 1'b0;
      @(negedge PCLK);
      n_checks++; if (bus.cmd_ready !== 1'b1) $display("FAIL rst_mid_cmd_ready: got %b want 1", bus.cmd_ready); else n_pass++;
      repeat (3) begin
         @(negedge PCLK);
         if (bus.rsp_valid || bus.PSELx) seen_rsp = 1'b1;
      end
      n_checks++; if (seen_rsp !== 1'b0) $display("FAIL rst_mid_no_rsp: got %b want 0", seen_rsp); else n_pass++;
      run_xfer(1'b0, 1'b0, 8'h00, 0, 1'b0, 8'h42);
      n_checks++; if (r_lat !== 3 || r_rdata !== 8'h42) $display("FAIL rst_mid_recover: got lat=%0d rdata=%h want 3/42", r_lat, r_rdata); else n_pass++;
      n_checks++; if (r_errcnt !== 8'h00) $display("FAIL rst_mid_recover_cnt: got %h want 00", r_errcnt); else n_pass++;
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_write();
      test_read_wait();
      test_error();
      test_timeout();
      test_back_to_back();
      test_reset_access();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/apb_master_ctrl.md
APB_MASTER_CTRL -- requirements
Module: apb_master_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16, giving the ACCESS-phase cycles without PREADY before abort (legal range 2..255).
REQ-002 The block SHALL have port PCLK, input, 1 bit, the single clock; all logic on its rising edge.
REQ-003 The block SHALL have port PRESET, input, 1 bit, the reset, which is synchronous and active-high.
REQ-004 The block SHALL have port cmd_valid, input, 1 bit, a command request.
REQ-005 The block SHALL have port cmd_ready, output, 1 bit, high when a command can be accepted.
REQ-006 The block SHALL have port cmd_write, input, 1 bit: 1 for a write, 0 for a read.
REQ-007 The block SHALL have port cmd_addr, input, 1 bit, the target address: 0 for the write port, 1 for the read port.
REQ-008 The block SHALL have port cmd_wdata, input, 8 bits, the write data.
REQ-009 The block SHALL have port rsp_valid, output, 1 bit, a one-cycle pulse marking transfer completion.
REQ-010 The block SHALL have port rsp_rdata, output, 8 bits, the read data.
REQ-011 The block SHALL have port rsp_err, output, 1 bit, set when the transfer ended with PSLVERR or timeout.
REQ-012 The block SHALL have port rsp_timeout, output, 1 bit, set when the transfer ended by timeout.
REQ-013 The block SHALL have port err_count, output, 8 bits, a saturating count of error responses.
REQ-014 The block SHALL have ports PSELx, PENABLE, PADDR and PWRITE, outputs, 1 bit each, the APB master control signals.
REQ-015 The block SHALL have port PWDATA, output, 8 bits, the APB write data.
REQ-016 The block SHALL have port PREADY, input, 1 bit, the APB completer ready.
REQ-017 The block SHALL have port PSLVERR, input, 1 bit, the APB completer error.
REQ-018 The block SHALL have port PRDATA, input, 8 bits, the APB read data.

Function
REQ-019 The block SHALL use an FSM with states IDLE, SETUP and ACCESS, and SHALL drive all outputs except cmd_ready from registers.
REQ-020 cmd_ready SHALL be 1 exactly when the state is IDLE (combinational decode); acceptance SHALL be cmd_valid&&cmd_ready at a rising edge.
REQ-021 On acceptance, the block SHALL load PADDR<=cmd_addr, PWRITE<=cmd_write and PWDATA<=cmd_wdata, go to SETUP, and drive PSELx=1, PENABLE=0.
REQ-022 From SETUP, the block SHALL go to ACCESS unconditionally after one cycle with PSELx=1, PENABLE=1.
REQ-023 PADDR, PWRITE and PWDATA SHALL be held stable from SETUP until the transfer ends, and SHALL keep their last values in IDLE.
REQ-024 In ACCESS with PREADY=1, at the edge the block SHALL go to IDLE, deassert PSELx and PENABLE, and pulse rsp_valid=1 for one cycle.
REQ-025 On that same edge, the block SHALL set rsp_err=PSLVERR, set rsp_timeout=0, and set rsp_rdata=PRDATA for reads or 8'h00 for writes.
REQ-026 The block SHALL have a wait counter that clears on SETUP->ACCESS and increments on each ACCESS cycle with PREADY=0.
REQ-027 If PREADY is still 0 when the wait counter equals TIMEOUT-1, the transfer SHALL abort: go to IDLE, pulse rsp_valid, set rsp_err=1, set rsp_timeout=1, set rsp_rdata=8'h00.
REQ-028 PREADY=1 in the cycle the timeout would fire SHALL take priority, giving a normal completion.
REQ-029 rsp_rdata, rsp_err and rsp_timeout SHALL hold until the next response.
REQ-030 err_count SHALL increment by 1 on each rsp_valid with rsp_err=1 and SHALL saturate at 8'hFF (no wrap).
REQ-031 The minimum transfer time SHALL be 3 cycles (accept edge, then SETUP, then ACCESS); rsp_valid is high in the IDLE cycle, in which a new command can be accepted (back-to-back).
REQ-032 The block SHALL never assert PENABLE without PSELx, SHALL never assert PSELx in IDLE, and SHALL ignore cmd_valid outside IDLE.
REQ-033 PSLVERR and PRDATA SHALL be sampled only in ACCESS with PREADY=1.

Reset
REQ-034 With PRESET=1 at a rising edge, the block SHALL go to IDLE and clear all registered outputs to 0: PSELx, PENABLE, PADDR, PWRITE, PWDATA, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, err_count and the wait counter.
REQ-035 A reset during SETUP or ACCESS SHALL abandon the transfer with no rsp_valid; PSELx=0 from the next cycle.
REQ-036 cmd_ready SHALL be 1 in the first cycle after reset release.

Verification
REQ-037 Write: cmd write=1, addr=0, wdata=8'hA5; PREADY=1 immediately -> SETUP/ACCESS with PWDATA=A5, PADDR=0; rsp_valid at cycle 3, rsp_err=0, err_count=0.
REQ-038 Read with wait states: addr=1, PREADY low 3 ACCESS cycles then high with PRDATA=8'h3C -> PSELx high 5 cycles total; rsp_rdata=3C.
REQ-039 Error: write with PREADY=1 and PSLVERR=1 -> rsp_err=1, rsp_timeout=0, err_count=1.
REQ-040 Timeout: PREADY stuck 0, TIMEOUT=16 -> abort after 16 ACCESS cycles; rsp_err=1, rsp_timeout=1; PREADY=1 exactly on cycle 16 -> normal completion.
REQ-041 Saturation/back-to-back: 260 consecutive PSLVERR transfers with cmd_valid held -> one transfer per 3 cycles, err_count stops at 8'hFF.
REQ-042 Reset in ACCESS: PRESET=1 pulsed mid-transfer -> PSELx=0, no rsp_valid, all outputs 0, cmd_ready=1 after release.
